// File: rtl/countdown_digits_bitmap.sv
// countdown_digits_bitmap
// On-screen countdown timer for the object-drawing chain. A binary seconds
// counter is loaded on startGame, decremented on an external 1 Hz strobe and
// flags expiry. The value is shown as NUM_DIGITS decimal digits from an
// internal 8x16 numeral font magnified by 2^SCALE_LOG2. Leading zeros are
// blanked. RGBout is registered (one cycle after the pixel inputs).
//
// Optional build macro: COUNTDOWN_LOW_BLINK_EN
//   When defined, the digits blink in ALERT_COLOR once per second while the
//   count is in 1..LOW_SEC, and are drawn steadily in ALERT_COLOR once the
//   timer has expired. When undefined, digits always use DIGIT_COLOR.

module countdown_digits_bitmap #(
  parameter int         NUM_DIGITS  = 3,
  parameter int         SCALE_LOG2  = 1,
  parameter int         START_SEC   = 99,
  parameter int         BONUS_SEC   = 10,
  parameter logic [7:0] DIGIT_COLOR = 8'hFF,
  parameter logic [7:0] ALERT_COLOR = 8'hE0,
  parameter int         LOW_SEC     = 10
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startGame,
  input  logic                    pause,
  input  logic                    oneSecPulse,
  input  logic                    addTime,
  input  logic [10:0]             offsetX,
  input  logic [10:0]             offsetY,
  input  logic                    InsideRectangle,
  output logic                    drawingRequest,
  output logic [7:0]              RGBout,
  output logic                    timeUp,
  output logic [4*NUM_DIGITS-1:0] secondsBCD
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int CNT_MAX = (10 ** NUM_DIGITS) - 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BCD_W   = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] MAX_C   = CNT_MAX[CNT_W-1:0];
  localparam logic [CNT_W-1:0] START_C = START_SEC[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [31:0]      MAX_W   = 32'(CNT_MAX);
  localparam logic [31:0]      BONUS_W = 32'(BONUS_SEC);

  // Timer states (kept as plain constants for compatibility with older blocks)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Binary to BCD by shift-and-add-3; the count never exceeds CNT_MAX, so
  // NUM_DIGITS BCD digits always suffice.
  function automatic logic [BCD_W-1:0] to_bcd(input logic [CNT_W-1:0] bin);
    logic [BCD_W-1:0] bcd;
    bcd = {BCD_W{1'b0}};
    for (int i = CNT_W - 1; i >= 0; i--) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (bcd[4*k +: 4] > 4'd4) begin
          bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end else begin
          bcd[4*k +: 4] = bcd[4*k +: 4];
        end
      end
      bcd = {bcd[BCD_W-2:0], bin[i]};
    end
    return bcd;
  endfunction

  // Numeral font: 16 rows of 8 pixels per glyph, row 0 in the top byte,
  // bit 7 of each row is the leftmost column.
  function automatic logic [7:0] font_row(input logic [3:0] digit,
                                          input logic [3:0] row);
    logic [127:0] glyph;
    case (digit)
      4'd0:    glyph = 128'h003C6666_6E6E7676_66666666_663C0000;
      4'd1:    glyph = 128'h00183878_18181818_18181818_187E0000;
      4'd2:    glyph = 128'h003C6666_06060C18_30606060_667E0000;
      4'd3:    glyph = 128'h003C6606_06061C06_06060606_663C0000;
      4'd4:    glyph = 128'h000C1C3C_6CCCCCFE_0C0C0C0C_0C1E0000;
      4'd5:    glyph = 128'h007E6060_607C0606_06060606_663C0000;
      4'd6:    glyph = 128'h003C6660_607C6666_66666666_663C0000;
      4'd7:    glyph = 128'h007E6606_060C0C18_18181818_18180000;
      4'd8:    glyph = 128'h003C6666_663C6666_66666666_663C0000;
      4'd9:    glyph = 128'h003C6666_66663E06_06060606_663C0000;
      default: glyph = 128'h00000000_00000000_00000000_00000000;
    endcase
    // Row r occupies bits [127-8r -: 8], i.e. a top index of {~r, 3'b111}.
    return glyph[{~row, 3'b111} -: 8];
  endfunction

  // ---------------------------------------------------------------------------
  // Timer state and count
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      sum_s;
  logic [CNT_W-1:0] sat_s;
  logic [BCD_W-1:0] bcd_s;

  // Saturating add of the bonus, done at 32 bits so the sum cannot wrap.
  always_comb begin
    sum_s = {{(32-CNT_W){1'b0}}, count_q} + BONUS_W;
    if (sum_s > MAX_W) begin
      sat_s = MAX_C;
    end else begin
      sat_s = sum_s[CNT_W-1:0];
    end
  end

  // Next state and count; startGame overrides everything else.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (startGame) begin
      state_d = ST_RUN;
      count_d = START_C;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          count_d = count_q;
        end
        ST_RUN: begin
          if (pause) begin
            // The strobe is ignored while paused; a bonus still applies.
            state_d = ST_PAUSED;
            if (addTime) begin
              count_d = sat_s;
            end else begin
              count_d = count_q;
            end
          end else if (count_q == ZERO_C) begin
            state_d = ST_EXPIRED;
            count_d = ZERO_C;
          end else if (addTime && oneSecPulse) begin
            // Bonus first, then the tick; the result is at least BONUS-1.
            state_d = ST_RUN;
            count_d = sat_s - ONE_C;
          end else if (addTime) begin
            state_d = ST_RUN;
            count_d = sat_s;
          end else if (oneSecPulse) begin
            if (count_q == ONE_C) begin
              state_d = ST_EXPIRED;
              count_d = ZERO_C;
            end else begin
              state_d = ST_RUN;
              count_d = count_q - ONE_C;
            end
          end else begin
            state_d = ST_RUN;
            count_d = count_q;
          end
        end
        ST_PAUSED: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else begin
            state_d = ST_RUN;
          end
          if (addTime) begin
            count_d = sat_s;
          end else begin
            count_d = count_q;
          end
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
          count_d = ZERO_C;
        end
        default: begin
          state_d = ST_IDLE;
          count_d = ZERO_C;
        end
      endcase
    end
  end

  // Timer state and count registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      count_q <= ZERO_C;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Decimal view of the count, used both for the port and for rendering.
  always_comb begin
    bcd_s = to_bcd(count_q);
  end

  assign secondsBCD = bcd_s;
  assign timeUp     = (state_q == ST_EXPIRED);

  // ---------------------------------------------------------------------------
  // Low-time blink phase (optional)
  // ---------------------------------------------------------------------------
`ifdef COUNTDOWN_LOW_BLINK_EN
  localparam logic [31:0] LOW_W = 32'(LOW_SEC);

  logic window_s;
  logic phase_q, phase_d;

  // Low window: running with 1..LOW_SEC seconds left.
  always_comb begin
    window_s = (state_q == ST_RUN) && (count_q != ZERO_C) &&
               ({{(32-CNT_W){1'b0}}, count_q} <= LOW_W);
  end

  // Phase flips on every counted second inside the low window, else clears.
  always_comb begin
    phase_d = 1'b0;
    if (window_s && !startGame) begin
      if (oneSecPulse && !pause) begin
        phase_d = ~phase_q;
      end else begin
        phase_d = phase_q;
      end
    end else begin
      phase_d = 1'b0;
    end
  end

  // Blink phase register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end
`else
  // Colour and threshold parameters only matter for the blink build.
  logic unused_cfg_s;
  assign unused_cfg_s = ^{ALERT_COLOR, 32'(LOW_SEC)};
`endif

  // ---------------------------------------------------------------------------
  // Pixel rendering
  // ---------------------------------------------------------------------------
  logic [10:0] dsel_s;
  logic [10:0] ys_s;
  logic [2:0]  col_s;
  logic [1:0]  idx_s;
  logic        digit_ok_s;
  logic        row_ok_s;
  logic [3:0]  digit_s;
  logic        shown_s;
  logic [7:0]  row_bits_s;
  logic        pix_s;
  logic [7:0]  rgb_d;
  logic [7:0]  rgb_q;

  // Map the pixel offset to a digit slot, glyph column and glyph row.
  always_comb begin
    dsel_s     = offsetX >> (3 + SCALE_LOG2);
    col_s      = 3'(offsetX >> SCALE_LOG2);
    ys_s       = offsetY >> SCALE_LOG2;
    digit_ok_s = (dsel_s < 11'(NUM_DIGITS));
    row_ok_s   = (ys_s < 11'd16);
    // Slot 0 is the most significant digit.
    idx_s      = 2'(NUM_DIGITS - 1) - dsel_s[1:0];
  end

  // Pick the digit in this slot; blank it if it is a leading zero.
  always_comb begin
    digit_s = 4'd0;
    shown_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx_s) == i) begin
        digit_s = bcd_s[4*i +: 4];
        shown_s = (i == 0) || (|(bcd_s >> (4*i)));
      end else begin
        digit_s = digit_s;
        shown_s = shown_s;
      end
    end
  end

  // Font lookup and opacity of the current pixel.
  always_comb begin
    row_bits_s = font_row(digit_s, ys_s[3:0]);
    pix_s      = InsideRectangle && digit_ok_s && row_ok_s && shown_s &&
                 row_bits_s[~col_s];
  end

  // Colour of the current pixel.
  always_comb begin
    rgb_d = 8'h00;
    if (!pix_s) begin
      rgb_d = 8'h00;
    end else begin
`ifdef COUNTDOWN_LOW_BLINK_EN
      if (state_q == ST_EXPIRED) begin
        rgb_d = ALERT_COLOR;
      end else if (window_s) begin
        rgb_d = phase_q ? ALERT_COLOR : 8'h00;
      end else begin
        rgb_d = DIGIT_COLOR;
      end
`else
      rgb_d = DIGIT_COLOR;
`endif
    end
  end

  // Output colour register: one cycle behind the pixel inputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q <= 8'h00;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign RGBout         = rgb_q;
  assign drawingRequest = (rgb_q != 8'h00);

endmodule

// File: tb/tb_countdown_digits_bitmap.sv
// Directed testbench for countdown_digits_bitmap with default parameters
// (3 digits, scale x2, start 99, bonus 10). Expected values are worked out
// by hand from the timer rules and the numeral font rows.

module tb_countdown_digits_bitmap;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startGame;
  logic        pause;
  logic        oneSecPulse;
  logic        addTime;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic        drawingRequest;
  logic [7:0]  RGBout;
  logic        timeUp;
  logic [11:0] secondsBCD;

  int n_vec = 0;
  int n_err = 0;

`ifdef COUNTDOWN_LOW_BLINK_EN
  localparam logic [7:0] EXP_COL = 8'hE0;
`else
  localparam logic [7:0] EXP_COL = 8'hFF;
`endif

  countdown_digits_bitmap dut (
    .clk            (clk),
    .resetN         (resetN),
    .startGame      (startGame),
    .pause          (pause),
    .oneSecPulse    (oneSecPulse),
    .addTime        (addTime),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .InsideRectangle(InsideRectangle),
    .drawingRequest (drawingRequest),
    .RGBout         (RGBout),
    .timeUp         (timeUp),
    .secondsBCD     (secondsBCD)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sec(input int n);
    for (int k = 0; k < n; k++) begin
      oneSecPulse = 1'b1;
      tick();
      oneSecPulse = 1'b0;
    end
  endtask

  task automatic add_bonus();
    addTime = 1'b1;
    tick();
    addTime = 1'b0;
  endtask

  task automatic add_and_sec();
    addTime     = 1'b1;
    oneSecPulse = 1'b1;
    tick();
    addTime     = 1'b0;
    oneSecPulse = 1'b0;
  endtask

  task automatic start();
    startGame = 1'b1;
    tick();
    startGame = 1'b0;
  endtask

  // Apply one pixel and check the registered colour after the next edge.
  task automatic pix(input string tag, input int x, input int y,
                     input logic [7:0] exp);
    offsetX = 11'(x);
    offsetY = 11'(y);
    tick();
    check_val(tag, {24'h0, RGBout}, {24'h0, exp});
    check_val({tag, "_dreq"}, {31'h0, drawingRequest}, {31'h0, (exp != 8'h00)});
  endtask

  initial begin
    resetN          = 1'b0;
    startGame       = 1'b0;
    pause           = 1'b0;
    oneSecPulse     = 1'b0;
    addTime         = 1'b0;
    offsetX         = 11'd0;
    offsetY         = 11'd0;
    InsideRectangle = 1'b0;

    // Reset state
    #12;
    check_val("rst_rgb",  {24'h0, RGBout}, 32'h00);
    check_val("rst_dreq", {31'h0, drawingRequest}, 32'h0);
    check_val("rst_tu",   {31'h0, timeUp}, 32'h0);
    check_val("rst_bcd",  {20'h0, secondsBCD}, 32'h000);
    resetN = 1'b1;
    tick();

    // IDLE ignores strobes and bonus
    sec(1);
    add_bonus();
    check_val("idle_bcd", {20'h0, secondsBCD}, 32'h000);
    check_val("idle_tu",  {31'h0, timeUp}, 32'h0);

    // Start and count down to expiry
    start();
    check_val("start_bcd", {20'h0, secondsBCD}, 32'h099);
    check_val("start_tu",  {31'h0, timeUp}, 32'h0);
    sec(98);
    check_val("cnt1_bcd", {20'h0, secondsBCD}, 32'h001);
    check_val("cnt1_tu",  {31'h0, timeUp}, 32'h0);
    sec(1);
    check_val("exp_bcd", {20'h0, secondsBCD}, 32'h000);
    check_val("exp_tu",  {31'h0, timeUp}, 32'h1);
    sec(1);
    add_bonus();
    check_val("exp_hold_bcd", {20'h0, secondsBCD}, 32'h000);
    check_val("exp_hold_tu",  {31'h0, timeUp}, 32'h1);

    // startGame wins over strobe and bonus in the same cycle
    startGame   = 1'b1;
    oneSecPulse = 1'b1;
    addTime     = 1'b1;
    tick();
    startGame   = 1'b0;
    oneSecPulse = 1'b0;
    addTime     = 1'b0;
    check_val("prio_bcd", {20'h0, secondsBCD}, 32'h099);
    check_val("prio_tu",  {31'h0, timeUp}, 32'h0);

    // Pause freezes the count; bonus still applies while paused
    sec(49);
    check_val("run50", {20'h0, secondsBCD}, 32'h050);
    pause = 1'b1;
    tick();
    sec(5);
    check_val("pause50", {20'h0, secondsBCD}, 32'h050);
    add_bonus();
    check_val("pause_add", {20'h0, secondsBCD}, 32'h060);
    pause = 1'b0;
    tick();
    sec(1);
    check_val("resume59", {20'h0, secondsBCD}, 32'h059);

    // Saturation at 999
    start();
    for (int k = 0; k < 90; k++) add_bonus();
    check_val("add999", {20'h0, secondsBCD}, 32'h999);
    sec(4);
    check_val("cnt995", {20'h0, secondsBCD}, 32'h995);
    add_bonus();
    check_val("sat999", {20'h0, secondsBCD}, 32'h999);
    add_and_sec();
    check_val("sat_tick", {20'h0, secondsBCD}, 32'h998);

    // Bonus plus tick together
    start();
    sec(59);
    check_val("cnt40", {20'h0, secondsBCD}, 32'h040);
    add_and_sec();
    check_val("add_tick49", {20'h0, secondsBCD}, 32'h049);
    sec(48);
    check_val("cnt1b", {20'h0, secondsBCD}, 32'h001);
    add_and_sec();
    check_val("add_tick_at1", {20'h0, secondsBCD}, 32'h010);
    check_val("add_tick_at1_tu", {31'h0, timeUp}, 32'h0);

    // Rendering "10" (paused so the colour is steady): MS zero blanked
    pause = 1'b1;
    tick();
    InsideRectangle = 1'b1;
    pix("lead_blank", 6, 2, 8'h00);
    pix("one_col3",  22, 2, 8'hFF);
    pix("one_col2",  20, 2, 8'h00);
    pix("zero_col2", 36, 2, 8'hFF);
    pix("zero_col0", 32, 2, 8'h00);

    // Rendering "7": top row of '7' is 0x7E, columns 1..6 lit
    pause = 1'b0;
    tick();
    sec(3);
    pause = 1'b1;
    tick();
    check_val("cnt7", {20'h0, secondsBCD}, 32'h007);
    for (int x = 0; x < 48; x++) begin
      int c;
      logic [7:0] e;
      c = (x >> 1) & 7;
      e = ((x >= 32) && (c >= 1) && (c <= 6)) ? 8'hFF : 8'h00;
      pix($sformatf("seven_x%0d", x), x, 2, e);
    end
    pix("seven_r7_c3", 38, 14, 8'hFF);
    pix("seven_r7_c2", 36, 14, 8'h00);
    pix("seven_r0",    36, 0,  8'h00);
    pix("row16",       36, 32, 8'h00);
    pix("digit3",      48, 2,  8'h00);

    // Registered output: holds until the next edge, then follows Inside=0
    pix("lat_on", 36, 2, 8'hFF);
    InsideRectangle = 1'b0;
    #1;
    check_val("lat_hold", {24'h0, RGBout}, 32'hFF);
    tick();
    check_val("outside", {24'h0, RGBout}, 32'h00);
    check_val("outside_dreq", {31'h0, drawingRequest}, 32'h0);

    // Expire, then asynchronous reset mid-cycle
    pause = 1'b0;
    tick();
    sec(7);
    check_val("exp2_tu", {31'h0, timeUp}, 32'h1);
    InsideRectangle = 1'b1;
    pix("exp_col", 36, 2, EXP_COL);
    #2;
    resetN = 1'b0;
    #1;
    check_val("arst_rgb",  {24'h0, RGBout}, 32'h00);
    check_val("arst_dreq", {31'h0, drawingRequest}, 32'h0);
    check_val("arst_tu",   {31'h0, timeUp}, 32'h0);
    check_val("arst_bcd",  {20'h0, secondsBCD}, 32'h000);
    resetN = 1'b1;
    tick();
    sec(5);
    check_val("post_rst_bcd", {20'h0, secondsBCD}, 32'h000);
    check_val("post_rst_tu",  {31'h0, timeUp}, 32'h0);

`ifdef COUNTDOWN_LOW_BLINK_EN
    // Low-time blink: phase flips on each second from 10 downwards
    start();
    sec(89);
    check_val("blink_cnt10", {20'h0, secondsBCD}, 32'h010);
    pix("blink10", 36, 2, 8'h00);
    sec(1);
    pix("blink9", 36, 2, 8'hE0);
    sec(1);
    pix("blink8", 36, 2, 8'h00);
    sec(1);
    pix("blink7", 36, 2, 8'hE0);
    sec(1);
    pix("blink6", 36, 2, 8'h00);
    sec(6);
    check_val("blink_exp_tu", {31'h0, timeUp}, 32'h1);
    pix("blink_exp_a", 36, 2, 8'hE0);
    sec(1);
    pix("blink_exp_b", 36, 2, 8'hE0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
